// File: rtl/mult_seq_ctrl.sv
// Multi-cycle radix-2 shift-add signed multiplier sequencer for the EX stage; owns HI/LO.
// Optional macro MULT_EARLY_TERM_EN: finish CALC as soon as the remaining multiplier bits are zero.
module mult_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_reg;
    logic [2*WIDTH-1:0]   mcand_reg;
    logic [2*WIDTH-1:0]   acc_reg;
    logic [WIDTH-1:0]     mplier_reg;
    logic                 neg_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [WIDTH-1:0]     hi_reg;
    logic [WIDTH-1:0]     lo_reg;
    logic                 done_reg;

    logic                 accept;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   result;
    logic                 last_iter;

    // Magnitudes: the most negative value maps onto itself, which is correct as unsigned.
    assign abs_a    = op_a[WIDTH-1] ? -op_a : op_a;
    assign abs_b    = op_b[WIDTH-1] ? -op_b : op_b;

    assign accept   = (state_reg == IDLE) && start && !flush;
    assign acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
    assign result   = neg_reg ? -acc_reg : acc_reg;

`ifdef MULT_EARLY_TERM_EN
    // Exit once the multiplier becomes zero after this cycle's shift.
    assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1)) || (mplier_reg[WIDTH-1:1] == '0);
`else
    assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));
`endif

    assign stall = accept || (state_reg == CALC);
    assign busy  = (state_reg != IDLE);
    assign done  = done_reg;
    assign hi    = hi_reg;
    assign lo    = lo_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            mcand_reg  <= '0;
            acc_reg    <= '0;
            mplier_reg <= '0;
            neg_reg    <= 1'b0;
            cnt_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (hi_we) begin
                        hi_reg <= wdata;
                    end
                    if (lo_we) begin
                        lo_reg <= wdata;
                    end
                    if (accept) begin
                        mcand_reg  <= {{WIDTH{1'b0}}, abs_a};
                        mplier_reg <= abs_b;
                        neg_reg    <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        acc_reg    <= '0;
                        cnt_reg    <= '0;
                        state_reg  <= CALC;
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_reg <= IDLE;
                    end else begin
                        acc_reg    <= acc_next;
                        mcand_reg  <= mcand_reg << 1;
                        mplier_reg <= mplier_reg >> 1;
                        cnt_reg    <= cnt_reg + CNT_W'(1);
                        if (last_iter) begin
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    // A squashed mult leaves HI/LO untouched.
                    state_reg <= IDLE;
                    if (!flush) begin
                        hi_reg   <= result[2*WIDTH-1:WIDTH];
                        lo_reg   <= result[WIDTH-1:0];
                        done_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Randomized self-checking bench for mult_seq_ctrl against a plain-arithmetic product model.
module tb_mult_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    always #5 clk = ~clk;

    mult_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .flush (flush),
        .op_a  (op_a),
        .op_b  (op_b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .stall (stall),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Expected number of CALC cycles from the magnitude of the multiplier.
    function automatic int exp_calc(input logic [31:0] b);
        logic [31:0] ab;
        int          n;
        ab = b[31] ? (32'd0 - b) : b;
        n  = 32;
`ifdef MULT_EARLY_TERM_EN
        n = 1;
        for (int i = 0; i < 32; i++) begin
            if (ab[i]) n = i + 1;
        end
`endif
        return n;
    endfunction

    task automatic mt_write(input bit whi, input bit wlo, input logic [31:0] d);
        @(negedge clk);
        hi_we = whi;
        lo_we = wlo;
        wdata = d;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (whi) hi_m = d;
        if (wlo) lo_m = d;
        chk("mt_hi", hi, hi_m);
        chk("mt_lo", lo, lo_m);
    endtask

    task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                            input bit mt_in_calc, input bit flush_done);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        p;
        int                 n;
        int                 dn;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        p  = sa * sb;
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        #1;
        n = 0;
        while (stall && n < 100) begin
            n++;
            if (mt_in_calc && n == 3) begin
                hi_we = 1'b1;
                lo_we = 1'b1;
                wdata = $urandom;
            end else begin
                hi_we = 1'b0;
                lo_we = 1'b0;
            end
            @(negedge clk);
        end
        hi_we = 1'b0;
        lo_we = 1'b0;
        start = 1'b0;
        if (flush_done) flush = 1'b1;
        chk("stall_len", 64'(n), 64'(exp_calc(b) + 1));
        if (!flush_done) begin
            hi_m = p[63:32];
            lo_m = p[31:0];
        end
        dn = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            flush = 1'b0;
            if (done) begin
                dn++;
                chk("hi_at_done", hi, hi_m);
                chk("lo_at_done", lo, lo_m);
            end
        end
        chk("done_cnt", 64'(dn), flush_done ? 64'd0 : 64'd1);
        chk("busy_after", busy, 1'b0);
        chk("hi_final", hi, hi_m);
        chk("lo_final", lo, lo_m);
        $display("mult a=%08h b=%08h stall=%0d flush_done=%0d hi=%08h lo=%08h", a, b, n, flush_done, hi, lo);
    endtask

    initial begin
        int n;
        int dn;
        int fc;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op_a  = '0;
        op_b  = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        #1;
        chk("rst_outs", {hi, lo}, 64'd0);
        chk("rst_flags", {stall, busy, done}, 3'b000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_flags", {stall, busy, done}, 3'b000);
        end
        chk("idle_outs", {hi, lo}, 64'd0);

        // Directed products.
        run_mult(32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_mult(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_mult(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        run_mult(32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        run_mult(32'd9, 32'd0, 1'b0, 1'b0);

        // mthi/mtlo then a mult squashed mid-CALC.
        mt_write(1'b1, 1'b0, 32'h0000_1234);
        mt_write(1'b0, 1'b1, 32'h0000_5678);
`ifdef MULT_EARLY_TERM_EN
        fc = 2;
`else
        fc = 10;
`endif
        @(negedge clk);
        op_a  = 32'd5;
        op_b  = 32'd5;
        start = 1'b1;
        #1;
        n = 0;
        while (stall && n < fc + 1) begin
            n++;
            if (n < fc + 1) @(negedge clk);
        end
        chk("flush_reach_calc", 64'(n), 64'(fc + 1));
        chk("flush_stall_calc", stall, 1'b1);
        flush = 1'b1;
        start = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", busy, 1'b0);
        chk("flush_stall", stall, 1'b0);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("flush_no_done", 64'(dn), 64'd0);
        chk("flush_hi", hi, hi_m);
        chk("flush_lo", lo, lo_m);
        $display("flush a=5 b=5 at_calc=%0d hi=%08h lo=%08h", fc, hi, lo);

        // Flush landing in the DONE cycle, and mt* attempts during CALC.
        run_mult(32'h0000_1111, 32'hFFFF_0003, 1'b0, 1'b1);
        run_mult(32'h1357_9BDF, 32'h0246_8ACE, 1'b1, 1'b0);

        // Randomized mults with occasional IDLE mt* writes.
        for (int t = 0; t < 24; t++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'h8000_0000;
                1: rb = $urandom_range(0, 300);
                2: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                mt_write($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
            end
            run_mult(ra, rb, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
        end

        // Asynchronous reset in CALC cycle 20.
        @(negedge clk);
        op_a  = $urandom;
        op_b  = 32'h7FFF_FFFF;
        start = 1'b1;
        #1;
        n = 0;
        while (stall && n < 21) begin
            n++;
            if (n < 21) @(negedge clk);
        end
        chk("rst_reach_calc", 64'(n), 64'd21);
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        hi_m = '0;
        lo_m = '0;
        chk("midrst_flags", {stall, busy, done}, 3'b000);
        chk("midrst_hi", hi, hi_m);
        chk("midrst_lo", lo, lo_m);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        chk("midrst_quiet", 64'(dn), 64'd0);
        chk("midrst_outs", {hi, lo}, 64'd0);
        $display("reset at calc cycle 20 hi=%08h lo=%08h", hi, lo);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Multi-cycle sequencer for the EX-stage multiply operation (ALU control code 4'b1000) in the pipelined MIPS core.
- Runs a radix-2 shift-add signed multiply and holds the pipeline via stall until the product is ready.
- Writes the 64-bit product into the HI/LO registers, which it owns; mthi/mtlo writes also go through it.
- Sits beside the ALU in EX. The hazard unit ORs stall into its pipeline freeze.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  EX holds a mult (ALUctl==4'b1000); level, held while stalled.
- flush  input  1  EX instruction squashed; abort the operation.
- op_a  input  WIDTH  multiplicand, signed; sampled on accept.
- op_b  input  WIDTH  multiplier, signed; sampled on accept.
- hi_we  input  1  mthi write.
- lo_we  input  1  mtlo write.
- wdata  input  WIDTH  mthi/mtlo data.
- stall  output  1  freeze IF/ID/EX.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse when HI/LO are updated.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- States: IDLE, CALC, DONE. On reset: state IDLE, hi=0, lo=0, done=0, stall=0, internal regs 0.
- IDLE, start=1 and flush=0 (accept):
  - Latch mcand = zero-extended |op_a| (2*WIDTH bits), mplier = |op_b| (WIDTH bits), neg = op_a[MSB]^op_b[MSB], acc=0, cnt=0.
  - Go to CALC.
  - |x| is the WIDTH-bit two's-complement negation taken as unsigned, so 0x80000000 -> 0x80000000.
- CALC, each cycle:
  - If mplier[0], acc += mcand.
  - Then mcand <<= 1, mplier >>= 1, cnt++.
  - When cnt == WIDTH-1, go to DONE. CALC lasts exactly WIDTH cycles.
- DONE:
  - {hi,lo} <= neg ? -acc : acc (2*WIDTH two's complement).
  - done=1 for this cycle; next state IDLE.
- stall (combinational) = (state==IDLE & start & ~flush) | (state==CALC).
  - stall is 0 in DONE, so the mult retires as DONE completes.
  - Total stall for WIDTH=32 is 33 cycles.
- The start level seen in the DONE cycle is ignored. A new accept is only possible from IDLE, i.e. back-to-back mults have a 1-cycle IDLE gap.
- flush in CALC or DONE: next state IDLE, hi/lo unchanged, done stays 0. flush in IDLE blocks accept.
- hi_we/lo_we:
  - Applied only in IDLE (hi<=wdata / lo<=wdata next edge).
  - Ignored in CALC and DONE. The pipeline is stalled then, so no legal mt* can be issued.
  - hi_we and lo_we together with the same wdata write both.
- rst_n low mid-operation: immediate abort, all state cleared. hi/lo go to 0, not the partial product.
- hi/lo are registered outputs, stable except on DONE edge, mt* writes, or reset.

Optional Feature:
- Macro MULT_EARLY_TERM_EN.
- Defined:
  - CALC also exits to DONE after any cycle where the post-shift mplier == 0.
  - CALC lasts max(1, index of highest set bit of |op_b| + 1) cycles, never more than WIDTH. The product is identical.
  - stall covers 1 + CALC cycles.
- Undefined: fixed WIDTH-cycle CALC as above; no zero-detect logic is synthesized.

Test Plan:
- Reset then idle: rst_n=0 -> hi=0, lo=0, stall=0, busy=0. Release, start=0 for 5 cycles -> all outputs unchanged.
- a=7, b=-3, start held until stall falls (macro off):
  - stall=1 for exactly 33 cycles; done pulses once.
  - hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000. Also a=-1, b=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF.
- flush:
  - mthi 0x1234 and mtlo 0x5678 in IDLE -> hi=0x1234, lo=0x5678.
  - Start a=5, b=5, then assert flush in CALC cycle 10 -> busy=0 next cycle, no done, hi/lo still 0x1234/0x5678.
- Reset mid-operation: rst_n pulsed low in CALC cycle 20 -> state IDLE at once; hi=0, lo=0, stall=0; no done afterwards.
- MULT_EARLY_TERM_EN defined:
  - a=-3, b=7 -> stall=1 for 4 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - a=9, b=0 -> stall=1 for 2 cycles, hi=0, lo=0.
